// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART frame constants and transmitter state encodings
package uart_tx_fifo_pkg;

    // Frame shape: 8 data bits, LSB first, one stop bit (8N1).
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Defaults for the serial bit period and the transmit buffer size.
    localparam int DEFAULT_DIV   = 234;
    localparam int DEFAULT_DEPTH = 16;

    // Transmitter FSM encodings, kept as plain constants so the receive side
    // can reuse the same numbering.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // One payload byte as carried through the FIFO and the shift register.
    typedef logic [DATA_BITS-1:0] byte_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - single-clock first-word-fall-through FIFO
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO or a read from an empty one is simply dropped,
    // so the occupancy counter can never wrap.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    // Head entry is presented combinationally: valid whenever !empty.
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset needed since the pointers define what is live.
    always_ff @(posedge clk) begin
        if (!rst && do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH (a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: a simultaneous write and read leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed from a byte FIFO
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DIV   = DEFAULT_DIV,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int              CW       = $clog2(DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

    logic [1:0]     state;
    logic [1:0]     state_n;
    logic [CW-1:0]  bit_cnt;
    logic [CW-1:0]  cnt_n;
    logic [2:0]     bit_idx;
    logic [2:0]     idx_n;
    byte_t          shift_reg;
    byte_t          shift_n;
    logic           tx_n;
    logic           busy_n;

    logic           fifo_full;
    logic           fifo_empty;
    byte_t          fifo_rd;
    logic           push;
    logic           pop;
    logic           bit_done;

    // Producer may push whenever there is room; a pop in the same cycle does
    // not open a slot early.
    assign tx_ready = !fifo_full;
    assign push     = tx_valid && tx_ready;
    // Bytes leave the FIFO only when the line is idle.
    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign bit_done = (bit_cnt == CNT_LAST);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state logic: the line level for the coming bit period is decided
    // here so that tx itself comes straight from a flop.
    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        idx_n   = bit_idx;
        shift_n = shift_reg;
        tx_n    = tx;
        case (state)
            ST_IDLE: begin
                tx_n  = 1'b1;
                cnt_n = '0;
                if (pop) begin
                    state_n = ST_START;
                    shift_n = fifo_rd;
                    idx_n   = '0;
                    tx_n    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = shift_reg[0];
                end else begin
                    cnt_n = bit_cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_n = '0;
                    if (bit_idx == IDX_LAST) begin
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        idx_n = bit_idx + 3'd1;
                        tx_n  = shift_reg[idx_n];
                    end
                end else begin
                    cnt_n = bit_cnt + CW'(1);
                end
            end
            default: begin
                tx_n = 1'b1;
                if (bit_done) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = bit_cnt + CW'(1);
                end
            end
        endcase
        // Busy covers an active frame plus anything still waiting in the FIFO,
        // so it stays high across the one idle cycle between queued frames.
        busy_n = (state_n != ST_IDLE) || !fifo_empty;
    end

    // State, counters and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= cnt_n;
            bit_idx   <= idx_n;
            shift_reg <= shift_n;
            tx        <= tx_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pushes = 0;
    int max_cnt = 0;

    int         st [6];
    int         cn [6];
    logic [7:0] exp_b [6];
    int         exp_c [6];
    int         p_cyc, s1, c1, lows, base, n, acc_cyc;
    logic       rdy;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // Edge counter and accepted-byte counter used as the bench's time base.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && tx_valid && tx_ready) pushes <= pushes + 1;
    end

    // Highest occupancy seen since the last clear.
    always @(negedge clk) begin
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick;
    endtask

    task automatic push(input logic [7:0] b);
        check("push_ready", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
    endtask

    // Reference sampler: find the start edge, then read each bit mid-period.
    task automatic recv(input string tag, input logic [7:0] exp, output int s, output int c);
        int k;
        logic [7:0] d;
        k = 0;
        d = 8'h00;
        while (tx !== 1'b0 && k < 300) begin
            tick;
            k++;
        end
        check({tag, "_start_seen"}, 32'(tx), 32'd0);
        s = cyc;
        c = int'(fifo_count);
        wait_until(s + DIV / 2);
        check({tag, "_start_bit"}, 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            wait_until(s + DIV / 2 + (i + 1) * DIV);
            d[i] = tx;
        end
        wait_until(s + DIV / 2 + 9 * DIV);
        check({tag, "_stop_bit"}, 32'(tx), 32'd1);
        check({tag, "_data"}, 32'(d), 32'(exp));
    endtask

    task automatic idle_watch(input int cycles, output int low_count);
        low_count = 0;
        repeat (cycles) begin
            tick;
            if (tx !== 1'b1) low_count++;
        end
    endtask

    initial begin
        exp_b = '{8'h11, 8'h00, 8'hFF, 8'h55, 8'hAA, 8'h3C};
        exp_c = '{1, 3, 3, 2, 1, 0};

        // Reset state
        rst = 1'b1;
        tick;
        tick;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        tick;
        tick;

        // 1: single byte 0xA5, latency and frame length
        push(8'hA5);
        p_cyc = cyc;
        check("t1_tx_after_push", 32'(tx), 32'd1);
        check("t1_count_after_push", 32'(fifo_count), 32'd1);
        recv("t1", 8'hA5, s1, c1);
        check("t1_start_latency", 32'(s1 - p_cyc), 32'd1);
        check("t1_count_after_pop", 32'(c1), 32'd0);
        wait_until(s1 + FRAME - 1);
        check("t1_busy_last_cycle", 32'(busy), 32'd1);
        check("t1_tx_last_cycle", 32'(tx), 32'd1);
        tick;
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_tx_end", 32'(tx), 32'd1);
        tick;

        // 2 + 3: fill the FIFO, then hold 0x3C valid until a slot opens
        base = pushes;
        fork
            begin
                push(8'h11);
                push(8'h00);
                push(8'hFF);
                push(8'h55);
                push(8'hAA);
                check("t2_full_count", 32'(fifo_count), 32'd4);
                check("t2_full_ready", 32'(tx_ready), 32'd0);
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
                n = 0;
                rdy = 1'b0;
                while (!rdy && n < 300) begin
                    rdy = tx_ready;
                    tick;
                    n++;
                end
                tx_valid = 1'b0;
                acc_cyc = cyc;
                check("t3_accept_seen", 32'(rdy), 32'd1);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    recv("t2", exp_b[k], st[k], cn[k]);
                end
            end
        join
        for (int k = 0; k < 6; k++) begin
            check("t2_count_at_start", 32'(cn[k]), 32'(exp_c[k]));
        end
        for (int k = 1; k < 6; k++) begin
            check("t2_spacing", 32'(st[k] - st[k-1]), 32'(FRAME + 1));
        end
        check("t3_accept_cycle", 32'(acc_cyc - st[1]), 32'd1);
        idle_watch(60, lows);
        check("t3_no_extra_frame", 32'(lows), 32'd0);
        check("t3_push_total", 32'(pushes - base), 32'd6);
        check("t3_busy_idle", 32'(busy), 32'd0);

        // 4: reset during DATA of 0x81 with two bytes queued
        push(8'h81);
        push(8'h42);
        push(8'h24);
        check("t4_queued", 32'(fifo_count), 32'd2);
        repeat (8) tick;
        check("t4_busy_mid", 32'(busy), 32'd1);
        rst      = 1'b1;
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        tick;
        rst      = 1'b0;
        tx_valid = 1'b0;
        check("t4_tx", 32'(tx), 32'd1);
        check("t4_count", 32'(fifo_count), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_ready", 32'(tx_ready), 32'd1);
        idle_watch(60, lows);
        check("t4_no_frames", 32'(lows), 32'd0);
        check("t4_count_after", 32'(fifo_count), 32'd0);

        // 5: eight bytes in two bursts, pointers wrap twice
        max_cnt = 0;
        fork
            begin
                push(8'h01);
                push(8'h02);
                push(8'h03);
                push(8'h04);
            end
            begin
                for (int k = 0; k < 4; k++) recv("t5a", 8'(k + 1), s1, c1);
            end
        join
        idle_watch(12, lows);
        check("t5_idle_between", 32'(lows), 32'd0);
        check("t5_busy_between", 32'(busy), 32'd0);
        fork
            begin
                push(8'h05);
                push(8'h06);
                push(8'h07);
                push(8'h08);
            end
            begin
                for (int k = 0; k < 4; k++) recv("t5b", 8'(k + 5), s1, c1);
            end
        join
        check("t5_max_count", 32'(max_cnt <= DEPTH), 32'd1);
        idle_watch(12, lows);
        check("t5_idle_end", 32'(lows), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
